tile_dma_mb: RTL and testbench

TILE_DMA_MB -- requirements
Module: tile_dma_mb

---
 rtl/tile_dma_mb.sv | 101 ++++++++++
 tb/tb_tile_dma_mb.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/tile_dma_mb.sv
// tile_dma_mb: streams host words into one of NBUF round-robin BRAM buffers
// and hands each filled buffer to a consumer until it is released.
module tile_dma_mb #(
    parameter int W     = 16,
    parameter int DEPTH = 256,
    parameter int NBUF  = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int BW   = $clog2(NBUF)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [AW:0]      start_len,
    input  logic             abort,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_data,
    output logic             bram_we,
    output logic [BW+AW-1:0] bram_waddr,
    output logic [W-1:0]     bram_wdata,
    output logic             load_done,
    output logic [BW-1:0]    done_buf,
    input  logic             rel_valid,
    input  logic [BW-1:0]    rel_buf,
    output logic             rel_err,
    output logic [NBUF-1:0]  full_mask,
    output logic             busy
);
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_e;
    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

    state_e          state_q, state_d;
    logic [BW-1:0]   wr_ptr_q, cur_buf_q, done_buf_q;
    logic [AW:0]     count_q, len_q, count_nx;
    logic [NBUF-1:0] full_mask_q, full_mask_d;
    logic            rel_err_q, accept, beat, last, rel_ok;

    assign accept   = start_valid & start_ready;
    assign beat     = in_valid & in_ready;
    assign count_nx = count_q + (AW+1)'(1);
    assign last     = count_nx == len_q;
    assign rel_ok   = rel_valid & full_mask_q[rel_buf];

    always_ff @(posedge clk or posedge rst)
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  state_d = accept ? S_LOAD : S_IDLE;
            S_LOAD:  state_d = abort ? S_IDLE : (beat && last) ? S_DONE : S_LOAD;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        start_ready = (state_q == S_IDLE) & ~full_mask_q[wr_ptr_q];
        in_ready    = (state_q == S_LOAD) & ~abort;
        load_done   = state_q == S_DONE;
        busy        = state_q != S_IDLE;
        done_buf    = load_done ? cur_buf_q : done_buf_q;
    end

    assign bram_we    = beat;
    assign bram_waddr = {cur_buf_q, count_q[AW-1:0]};
    assign bram_wdata = in_data;
    assign rel_err    = rel_err_q;
    assign full_mask  = full_mask_q;

    // A release is judged against the pre-cycle mask, so it cannot cancel a same-cycle fill.
    assign full_mask_d = (full_mask_q & ~(rel_ok ? NBUF'(1) << rel_buf : '0))
                       | (load_done ? NBUF'(1) << cur_buf_q : '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            cur_buf_q   <= '0;
            done_buf_q  <= '0;
            count_q     <= '0;
            len_q       <= '0;
            full_mask_q <= '0;
            rel_err_q   <= 1'b0;
        end else begin
            if (accept) begin
                len_q     <= (start_len == '0 || start_len > DEPTH_L) ? DEPTH_L : start_len;
                cur_buf_q <= wr_ptr_q;
                count_q   <= '0;
            end else if (beat) begin
                count_q <= count_nx;
            end
            if (load_done) begin
                wr_ptr_q   <= wr_ptr_q + 1'b1;
                done_buf_q <= cur_buf_q;
            end
            full_mask_q <= full_mask_d;
            rel_err_q   <= rel_valid & ~full_mask_q[rel_buf];
        end
    end
endmodule

// File: tb/tb_tile_dma_mb.sv
// tb_tile_dma_mb: directed bench for tile_dma_mb with a transaction-level
// buffer/ownership model checked every cycle plus literal spot checks.
module tb_tile_dma_mb;
    localparam int W = 16, DEPTH = 256, NBUF = 4, AW = 8, BW = 2;

    logic             clk = 0, rst = 1;
    logic             start_valid = 0, start_ready;
    logic [AW:0]      start_len = 0;
    logic             abort = 0, in_valid = 0, in_ready;
    logic [W-1:0]     in_data = 0;
    logic             bram_we;
    logic [BW+AW-1:0] bram_waddr;
    logic [W-1:0]     bram_wdata;
    logic             load_done;
    logic [BW-1:0]    done_buf;
    logic             rel_valid = 0;
    logic [BW-1:0]    rel_buf = 0;
    logic             rel_err;
    logic [NBUF-1:0]  full_mask;
    logic             busy;

    tile_dma_mb #(.W(W), .DEPTH(DEPTH), .NBUF(NBUF)) dut (
        .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(start_ready),
        .start_len(start_len), .abort(abort), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .bram_we(bram_we), .bram_waddr(bram_waddr), .bram_wdata(bram_wdata),
        .load_done(load_done), .done_buf(done_buf), .rel_valid(rel_valid), .rel_buf(rel_buf),
        .rel_err(rel_err), .full_mask(full_mask), .busy(busy)
    );

    always #5 clk = ~clk;

    int tests = 0, fails = 0;
    int we_cnt = 0, done_cnt = 0;
    int addrs[$];

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    // Model: phase 0 idle / 1 filling / 2 handing over; ownership kept as a plain bit array.
    int        m_ph = 0, m_wr = 0, m_buf = 0, m_cnt = 0, m_len = 0, m_done_buf = 0;
    bit [3:0]  m_mask = 0, nmask;
    bit        m_rel_err = 0, e_sr, e_ir, e_we;

    always @(negedge clk) begin
        if (bram_we === 1'b1) begin
            we_cnt++;
            addrs.push_back(int'(bram_waddr));
        end
        if (load_done === 1'b1) done_cnt++;
        if (rst) begin
            m_ph = 0; m_wr = 0; m_buf = 0; m_cnt = 0; m_mask = 0; m_rel_err = 0; m_done_buf = 0;
            chk("rst_busy", busy, 0);
            chk("rst_in_ready", in_ready, 0);
            chk("rst_bram_we", bram_we, 0);
            chk("rst_load_done", load_done, 0);
            chk("rst_rel_err", rel_err, 0);
            chk("rst_full_mask", full_mask, 0);
            chk("rst_done_buf", done_buf, 0);
        end else begin
            e_sr = (m_ph == 0) && !m_mask[m_wr];
            e_ir = (m_ph == 1) && !abort;
            e_we = e_ir && in_valid;
            chk("start_ready", start_ready, e_sr);
            chk("in_ready", in_ready, e_ir);
            chk("bram_we", bram_we, e_we);
            chk("load_done", load_done, m_ph == 2);
            chk("busy", busy, m_ph != 0);
            chk("full_mask", full_mask, m_mask);
            chk("rel_err", rel_err, m_rel_err);
            chk("done_buf", done_buf, m_ph == 2 ? m_buf : m_done_buf);
            if (e_we) begin
                chk("waddr", bram_waddr, m_buf * DEPTH + m_cnt);
                chk("wdata", bram_wdata, in_data);
            end
            nmask = m_mask;
            if (rel_valid && m_mask[rel_buf]) nmask[rel_buf] = 0;
            m_rel_err = rel_valid && !m_mask[rel_buf];
            case (m_ph)
                0: if (start_valid && e_sr) begin
                       m_len = (start_len == 0 || start_len > DEPTH) ? DEPTH : int'(start_len);
                       m_buf = m_wr; m_cnt = 0; m_ph = 1;
                   end
                1: if (abort) m_ph = 0;
                   else if (in_valid) begin
                       m_cnt++;
                       if (m_cnt == m_len) m_ph = 2;
                   end
                default: begin
                    nmask[m_buf] = 1; m_done_buf = m_buf; m_wr = (m_wr + 1) % NBUF; m_ph = 0;
                end
            endcase
            m_mask = nmask;
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic start(input int len);
        start_len = (AW+1)'(len);
        start_valid = 1;
        for (int i = 0; i < 50 && !start_ready; i++) step();
        chk("start_accept", start_ready, 1);
        step();
        start_valid = 0;
    endtask

    task automatic stream(input int n, input int base, input bit gaps);
        for (int k = 0; k < n; k++) begin
            in_valid = 1; in_data = W'(base + k);
            step();
            if (gaps) begin in_valid = 0; step(); end
        end
        in_valid = 0;
    endtask

    task automatic do_reset();
        rst = 1; step(); rst = 0; step();
    endtask

    int a0, w0, d0;

    initial begin
        step(3); rst = 0; step();
        chk("sr_after_reset", start_ready, 1);
        // full-depth load of buffer 0
        a0 = addrs.size(); w0 = we_cnt;
        start(256); stream(256, 0, 0);
        chk("r22_load_done", load_done, 1);
        chk("r22_done_buf", done_buf, 0);
        chk("r22_writes", we_cnt - w0, 256);
        chk("r22_first_addr", addrs[a0], 0);
        chk("r22_last_addr", addrs[$], 255);
        step();
        chk("r22_mask", full_mask, 4'b0001);
        // four short loads, round-robin
        do_reset();
        a0 = addrs.size();
        for (int b = 0; b < 4; b++) begin start(4); stream(4, 16 * b + 7, 0); step(); end
        for (int i = 0; i < 16; i++) chk("r23_addr", addrs[a0 + i], (i / 4) * 256 + i % 4);
        chk("r23_mask", full_mask, 4'hF);
        start_valid = 1; start_len = 4; step();
        chk("r23_fifth_blocked", start_ready, 0);
        // release with pending start
        rel_valid = 1; rel_buf = 0; step(); rel_valid = 0;
        chk("r24_mask_after_rel", full_mask, 4'hE);
        chk("r24_sr_after_rel", start_ready, 1);
        step(); start_valid = 0;
        chk("r24_accepted", busy, 1);
        stream(4, 300, 0);
        chk("r24_done_buf", done_buf, 0);
        rel_valid = 1; rel_buf = 0; step(); rel_valid = 0;
        chk("r16_mask_kept", full_mask, 4'hF);
        chk("r16_rel_err", rel_err, 1);
        step();
        chk("r16_rel_err_pulse", rel_err, 0);
        rel_valid = 1; step(); rel_valid = 0;
        chk("r24_legal_no_err", rel_err, 0);
        chk("r24_mask_e", full_mask, 4'hE);
        rel_valid = 1; step(); rel_valid = 0;
        chk("r24_illegal_err", rel_err, 1);
        chk("r24_mask_e2", full_mask, 4'hE);
        step();
        chk("r24_err_pulse", rel_err, 0);
        // abort mid-load with gappy stream
        do_reset();
        w0 = we_cnt; d0 = done_cnt;
        start(10); stream(5, 50, 1);
        abort = 1; in_valid = 1; step(); abort = 0; in_valid = 0;
        chk("r25_idle", busy, 0);
        step(3);
        chk("r25_writes", we_cnt - w0, 5);
        chk("r25_no_done", done_cnt - d0, 0);
        chk("r25_mask", full_mask, 0);
        a0 = addrs.size();
        start(2); stream(2, 60, 0); step();
        chk("r25_reuse_addr", addrs[a0], 0);
        chk("r25_reuse_mask", full_mask, 4'b0001);
        // length clamping and reset mid-load
        do_reset();
        w0 = we_cnt; start(0); stream(256, 1000, 0); step();
        chk("r26_len0_writes", we_cnt - w0, 256);
        chk("r26_len0_mask", full_mask, 4'b0001);
        w0 = we_cnt; start(300); stream(256, 2000, 0); step();
        chk("r26_len300_writes", we_cnt - w0, 256);
        chk("r26_len300_mask", full_mask, 4'b0011);
        d0 = done_cnt;
        start(256); stream(100, 3000, 0);
        rst = 1; step();
        chk("r26_rst_busy", busy, 0);
        chk("r26_rst_mask", full_mask, 0);
        rst = 0; step();
        chk("r26_no_done", done_cnt - d0, 0);
        chk("r26_sr", start_ready, 1);
        a0 = addrs.size();
        start(3); stream(3, 4000, 0); step();
        chk("r26_wrptr0_addr", addrs[a0], 0);
        chk("r26_final_mask", full_mask, 4'b0001);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end
endmodule
